spi_bus_scheduler: RTL and testbench
====================================

// Module: spi_bus_scheduler
// PURPOSE
//  Shares one SPI byte-transfer engine (begin/end handshake, 8-bit send/receive) between
//  NUM_REQ on-board peripherals (gyro, accelerometer, ...). Round-robin arbitration per burst.
//  Owns all per-device active-low chip selects and enforces CS setup/hold/gap timing.
//  Aborts a transfer if the engine hangs. Sits between device controllers and the SPI engine.
// PARAMETERS
//  NUM_REQ     2    number of requesters / chip selects (>=2)
//  CS_SETUP    4    clk cycles between CS assert and first begin pulse (>=1)
//  CS_HOLD     4    clk cycles between last byte end and CS deassert (>=1)
//  CS_GAP      8    min clk cycles with all CS high between bursts (>=1)
//  TIMEOUT     4096 max clk cycles waiting for spi_end; 0 disables the watchdog
// PORTS
//  clk            in   1          system clock
//  rst            in   1          async reset, active-high
//  req            in   NUM_REQ    requester i wants a byte transferred; hold until req_ack
//  req_last       in   NUM_REQ    byte offered by i is the final byte of its burst
//  req_data       in   8*NUM_REQ  byte to send; slice i = [8*i+7:8*i]
//  req_ack        out  NUM_REQ    1-cycle pulse: requester i's byte was latched
//  rsp_valid      out  NUM_REQ    1-cycle pulse: rsp_data holds byte received for i
//  rsp_data       out  8          received byte (shared, valid with rsp_valid)
//  grant          out  NUM_REQ    one-hot owner of bus, high from ARB exit through HOLD
//  err_timeout    out  NUM_REQ    1-cycle pulse: owner's transfer aborted by watchdog
//  cs_n           out  NUM_REQ    per-device chip select, active-low
//  spi_begin      out  1          1-cycle start pulse to engine
//  spi_send_data  out  8          byte to engine, stable from spi_begin until spi_end
//  spi_end        in   1          1-cycle done pulse from engine
//  spi_recv_data  in   8          byte from engine, valid with spi_end
// BEHAVIOUR
//  Reset: state IDLE, cs_n all 1, grant/req_ack/rsp_valid/err_timeout 0, spi_begin 0,
//   spi_send_data 0, rsp_data 0, rr pointer 0, counters 0. Reset mid-burst releases CS at once.
//  FSM: IDLE -> SETUP -> START -> WAIT -> (START | HOLD) -> GAP -> IDLE.
//  IDLE: if any req, pick first asserted index at or after rr pointer (wrapping); register
//   grant, drive that cs_n low next cycle; rr pointer <= winner+1 mod NUM_REQ.
//  SETUP: count CS_SETUP cycles with CS low, then START.
//  START: latch req_data[winner] into spi_send_data and req_last into last_r; pulse req_ack
//   and spi_begin in the same cycle; go WAIT.
//  WAIT: on spi_end: rsp_data <= spi_recv_data, rsp_valid[winner] pulse next cycle.
//   If !last_r and req[winner] high -> START (CS stays low, no setup). Else -> HOLD.
//   Requester dropping req without last ends the burst normally.
//  Back-to-back bytes: spi_end cycle N -> spi_begin at cycle N+1 at the earliest.
//  Watchdog: counts cycles in WAIT; at TIMEOUT without spi_end, pulse err_timeout[winner],
//   no rsp_valid, go HOLD. spi_end arriving later is ignored.
//  HOLD: count CS_HOLD cycles, then cs_n all 1, grant 0 -> GAP.
//  GAP: count CS_GAP cycles with all CS high, then IDLE. Requests seen in GAP wait.
//  spi_end outside WAIT ignored. req_data/req_last of non-granted requesters ignored.
//  At most one cs_n low at any time; cs_n low implies grant of same index.
//  Single requester holding req continuously still yields after each burst (rr).
//  Counters sized $clog2(max(param)+1); no wrap before terminal count.
// STRUCTURE
//  spi_sched_pkg: state enum (IDLE,SETUP,START,WAIT,HOLD,GAP), SPI_BYTE_W=8.
//  Sub-module rr_arbiter #(N): comb one-hot pick from req vector + pointer; the rest,
//  FSM, counters, watchdog, output registers, stays in this module.
// TESTING
//  Engine model: spi_end 16 cycles after spi_begin, spi_recv_data = ~spi_send_data.
//  1. req[0], last=1, data 0xA5 -> cs_n=2'b10 for SETUP+1+16+HOLD cycles, one req_ack,
//     rsp_valid[0] with rsp_data 0x5A, then all CS high >= 8 cycles.
//  2. req[1] 3-byte burst 0x01,0x02,0x03(last) -> cs_n[1] low continuously, 3 spi_begin
//     pulses, rsp 0xFE,0xFD,0xFC, single setup and single hold period.
//  3. req[0] and req[1] both held, 1-byte bursts -> grants alternate 0,1,0,1; never both CS low.
//  4. Engine withholds spi_end, TIMEOUT=64 -> err_timeout[owner] at 64 cycles in WAIT,
//     no rsp_valid, CS released after HOLD; late spi_end ignored, next request served.
//  5. rst asserted during WAIT of a burst -> cs_n all 1 and grant 0 immediately (async);
//     after release, IDLE and rr pointer 0.

Source files
------------

// File: rtl/spi_sched_pkg.sv
// Shared types and helpers for the SPI bus scheduler: FSM state encoding and byte width.
package spi_sched_pkg;

    localparam int SPI_BYTE_W = 8;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        START,
        WAIT,
        HOLD,
        GAP
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/spi_bus_scheduler_rr_arbiter.sv
// Combinational round-robin pick: first asserted request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic [N-1:0]         req,
    input  logic [$clog2(N)-1:0] ptr,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] grant_idx,
    output logic                 valid
);

    localparam int PW = $clog2(N);

    always_comb begin
        int idx;
        grant     = '0;
        grant_idx = '0;
        valid     = 1'b0;
        idx       = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!valid && req[idx]) begin
                valid      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/spi_bus_scheduler.sv
// Time-shares one SPI byte engine between NUM_REQ devices, owning their chip selects
// and enforcing CS setup/hold/gap plus a watchdog on the engine's done pulse.
module spi_bus_scheduler
    import spi_sched_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_GAP   = 8,
    parameter int TIMEOUT  = 4096
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ-1:0]          req_last,
    input  logic [8*NUM_REQ-1:0]        req_data,
    output logic [NUM_REQ-1:0]          req_ack,
    output logic [NUM_REQ-1:0]          rsp_valid,
    output logic [SPI_BYTE_W-1:0]       rsp_data,
    output logic [NUM_REQ-1:0]          grant,
    output logic [NUM_REQ-1:0]          err_timeout,
    output logic [NUM_REQ-1:0]          cs_n,
    output logic                        spi_begin,
    output logic [SPI_BYTE_W-1:0]       spi_send_data,
    input  logic                        spi_end,
    input  logic [SPI_BYTE_W-1:0]       spi_recv_data
);

    localparam int PW     = $clog2(NUM_REQ);
    localparam int CW     = $clog2(max_int(max_int(CS_SETUP, CS_HOLD), CS_GAP) + 1);
    localparam int TO_EFF = max_int(TIMEOUT, 1);
    localparam int WW     = $clog2(TO_EFF + 1);
    localparam bit WD_EN  = (TIMEOUT != 0);

    localparam logic [CW-1:0] SETUP_LAST = CW'(CS_SETUP - 1);
    localparam logic [CW-1:0] HOLD_LAST  = CW'(CS_HOLD - 1);
    localparam logic [CW-1:0] GAP_LAST   = CW'(CS_GAP - 1);
    localparam logic [WW-1:0] WD_LAST    = WW'(TO_EFF - 1);
    localparam logic [PW-1:0] IDX_LAST   = PW'(NUM_REQ - 1);

    sched_state_t          state_reg;
    logic [PW-1:0]         rr_ptr_reg;
    logic [PW-1:0]         winner_reg;
    logic [CW-1:0]         cnt_reg;
    logic [WW-1:0]         wd_cnt_reg;
    logic                  last_reg;
    logic [NUM_REQ-1:0]    grant_reg;
    logic [NUM_REQ-1:0]    cs_n_reg;
    logic [NUM_REQ-1:0]    req_ack_reg;
    logic [NUM_REQ-1:0]    rsp_valid_reg;
    logic [NUM_REQ-1:0]    err_reg;
    logic                  spi_begin_reg;
    logic [SPI_BYTE_W-1:0] send_data_reg;
    logic [SPI_BYTE_W-1:0] rsp_data_reg;

    logic [NUM_REQ-1:0]    arb_grant;
    logic [PW-1:0]         arb_idx;
    logic                  arb_valid;
    logic [PW-1:0]         rr_next;
    logic [SPI_BYTE_W-1:0] req_bytes [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_bytes[gi] = req_data[gi*SPI_BYTE_W +: SPI_BYTE_W];
        end
    endgenerate

    rr_arbiter #(.N(NUM_REQ)) u_arb (
        .req       (req),
        .ptr       (rr_ptr_reg),
        .grant     (arb_grant),
        .grant_idx (arb_idx),
        .valid     (arb_valid)
    );

    assign rr_next = (arb_idx == IDX_LAST) ? '0 : arb_idx + PW'(1);

    // Byte launch outputs are registered on entry to START so spi_begin is seen during START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            rr_ptr_reg    <= '0;
            winner_reg    <= '0;
            cnt_reg       <= '0;
            wd_cnt_reg    <= '0;
            last_reg      <= 1'b0;
            grant_reg     <= '0;
            cs_n_reg      <= '1;
            req_ack_reg   <= '0;
            rsp_valid_reg <= '0;
            err_reg       <= '0;
            spi_begin_reg <= 1'b0;
            send_data_reg <= '0;
            rsp_data_reg  <= '0;
        end else begin
            req_ack_reg   <= '0;
            rsp_valid_reg <= '0;
            err_reg       <= '0;
            spi_begin_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (arb_valid) begin
                        grant_reg  <= arb_grant;
                        cs_n_reg   <= ~arb_grant;
                        winner_reg <= arb_idx;
                        rr_ptr_reg <= rr_next;
                        cnt_reg    <= '0;
                        state_reg  <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_reg == SETUP_LAST) begin
                        send_data_reg <= req_bytes[winner_reg];
                        last_reg      <= req_last[winner_reg];
                        req_ack_reg   <= grant_reg;
                        spi_begin_reg <= 1'b1;
                        state_reg     <= START;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                START: begin
                    wd_cnt_reg <= '0;
                    state_reg  <= WAIT;
                end
                WAIT: begin
                    if (spi_end) begin
                        rsp_data_reg  <= spi_recv_data;
                        rsp_valid_reg <= grant_reg;
                        if (!last_reg && req[winner_reg]) begin
                            send_data_reg <= req_bytes[winner_reg];
                            last_reg      <= req_last[winner_reg];
                            req_ack_reg   <= grant_reg;
                            spi_begin_reg <= 1'b1;
                            state_reg     <= START;
                        end else begin
                            cnt_reg   <= '0;
                            state_reg <= HOLD;
                        end
                    end else if (WD_EN && wd_cnt_reg == WD_LAST) begin
                        err_reg   <= grant_reg;
                        cnt_reg   <= '0;
                        state_reg <= HOLD;
                    end else if (WD_EN) begin
                        wd_cnt_reg <= wd_cnt_reg + WW'(1);
                    end
                end
                HOLD: begin
                    if (cnt_reg == HOLD_LAST) begin
                        cs_n_reg  <= '1;
                        grant_reg <= '0;
                        cnt_reg   <= '0;
                        state_reg <= GAP;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                GAP: begin
                    if (cnt_reg == GAP_LAST) begin
                        state_reg <= IDLE;
                    end else begin
                        cnt_reg <= cnt_reg + CW'(1);
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign req_ack       = req_ack_reg;
    assign rsp_valid     = rsp_valid_reg;
    assign rsp_data      = rsp_data_reg;
    assign grant         = grant_reg;
    assign err_timeout   = err_reg;
    assign cs_n          = cs_n_reg;
    assign spi_begin     = spi_begin_reg;
    assign spi_send_data = send_data_reg;

endmodule

// File: tb/tb_spi_bus_scheduler.sv
// Directed bench for spi_bus_scheduler with a 16-cycle SPI engine model returning ~data.
module tb_spi_bus_scheduler;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [1:0]  req_last;
    logic [15:0] req_data;
    logic [1:0]  req_ack;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_data;
    logic [1:0]  grant;
    logic [1:0]  err_timeout;
    logic [1:0]  cs_n;
    logic        spi_begin;
    logic [7:0]  spi_send_data;
    logic        spi_end;
    logic [7:0]  spi_recv_data;

    int checks = 0;
    int errors = 0;

    spi_bus_scheduler #(
        .NUM_REQ (2),
        .CS_SETUP(4),
        .CS_HOLD (4),
        .CS_GAP  (8),
        .TIMEOUT (64)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req          (req),
        .req_last     (req_last),
        .req_data     (req_data),
        .req_ack      (req_ack),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .grant        (grant),
        .err_timeout  (err_timeout),
        .cs_n         (cs_n),
        .spi_begin    (spi_begin),
        .spi_send_data(spi_send_data),
        .spi_end      (spi_end),
        .spi_recv_data(spi_recv_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Engine model: spi_end asserted eng_delay cycles after the spi_begin cycle.
    int         eng_delay = 16;
    int         eng_cnt   = 0;
    logic       eng_busy  = 1'b0;
    logic [7:0] eng_data  = 8'h00;
    initial begin
        spi_end       = 1'b0;
        spi_recv_data = 8'h00;
    end
    always @(posedge clk) begin
        spi_end <= 1'b0;
        if (spi_begin) begin
            eng_busy <= 1'b1;
            eng_cnt  <= 1;
            eng_data <= ~spi_send_data;
        end else if (eng_busy) begin
            eng_cnt <= eng_cnt + 1;
            if (eng_cnt == eng_delay - 1) begin
                spi_end       <= 1'b1;
                spi_recv_data <= eng_data;
                eng_busy      <= 1'b0;
            end
        end
    end

    // Passive monitor: event counters and logs, read by the directed sequence.
    int         n_ack = 0, n_begin = 0, n_rsp = 0, n_err = 0, n_end = 0, n_viol = 0;
    int         n_cs_assert = 0, low_run = 0, high_run = 0, last_low_len = 0, min_gap = 1000;
    logic       prev_low = 1'b0;
    logic [7:0] rsp_log [64];
    logic [1:0] rsp_idx_log [64];
    always @(negedge clk) begin
        if (req_ack != 2'b00) n_ack <= n_ack + 1;
        if (spi_begin) n_begin <= n_begin + 1;
        if (err_timeout != 2'b00) n_err <= n_err + 1;
        if (spi_end) n_end <= n_end + 1;
        if (rsp_valid != 2'b00 && n_rsp < 64) begin
            rsp_log[n_rsp]     <= rsp_data;
            rsp_idx_log[n_rsp] <= rsp_valid;
            n_rsp              <= n_rsp + 1;
        end
        if ((cs_n == 2'b00) || ((~cs_n & ~grant) != 2'b00)) n_viol <= n_viol + 1;
        if (cs_n != 2'b11) begin
            if (!prev_low) begin
                n_cs_assert <= n_cs_assert + 1;
                if (n_cs_assert > 0 && high_run < min_gap) min_gap <= high_run;
                low_run <= 1;
            end else begin
                low_run <= low_run + 1;
            end
            prev_low <= 1'b1;
        end else begin
            if (prev_low) begin
                last_low_len <= low_run;
                high_run     <= 1;
            end else begin
                high_run <= high_run + 1;
            end
            prev_low <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input int idx, input logic [7:0] d, input logic last);
        int k;
        req[idx]             = 1'b1;
        req_data[idx*8 +: 8] = d;
        req_last[idx]        = last;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!req_ack[idx] && k < 300);
        check("ack_wait", 32'(k < 300), 32'd1);
        $display("byte req%0d data=%02h last=%0b acked after %0d cycles", idx, d, last, k);
    endtask

    int         a0, b0, r0, e0, c0, v0, k;
    logic [1:0] ack_seq [4];

    initial begin
        rst      = 1'b1;
        req      = 2'b00;
        req_last = 2'b00;
        req_data = 16'h0000;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_cs_n", 32'(cs_n), 32'h3);
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_begin", 32'(spi_begin), 32'h0);
        check("rst_send_data", 32'(spi_send_data), 32'h0);
        check("rst_rsp_data", 32'(rsp_data), 32'h0);
        check("rst_pulses", 32'({req_ack, rsp_valid, err_timeout}), 32'h0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // 1: single byte from requester 0
        a0 = n_ack; b0 = n_begin; r0 = n_rsp; c0 = n_cs_assert;
        send_byte(0, 8'hA5, 1'b1);
        check("t1_cs_n_owner", 32'(cs_n), 32'h2);
        req[0] = 1'b0;
        repeat (40) @(negedge clk);
        check("t1_acks", 32'(n_ack - a0), 32'd1);
        check("t1_begins", 32'(n_begin - b0), 32'd1);
        check("t1_rsp_cnt", 32'(n_rsp - r0), 32'd1);
        check("t1_rsp_data", 32'(rsp_log[r0]), 32'h5A);
        check("t1_rsp_idx", 32'(rsp_idx_log[r0]), 32'h1);
        check("t1_cs_low_len", 32'(last_low_len), 32'd25);
        check("t1_cs_asserts", 32'(n_cs_assert - c0), 32'd1);
        $display("test1 done cs_low_len=%0d rsp=%02h", last_low_len, rsp_log[r0]);

        // 2: three-byte burst from requester 1
        a0 = n_ack; b0 = n_begin; r0 = n_rsp; c0 = n_cs_assert;
        send_byte(1, 8'h01, 1'b0);
        send_byte(1, 8'h02, 1'b0);
        send_byte(1, 8'h03, 1'b1);
        req[1] = 1'b0;
        repeat (40) @(negedge clk);
        check("t2_acks", 32'(n_ack - a0), 32'd3);
        check("t2_begins", 32'(n_begin - b0), 32'd3);
        check("t2_rsp0", 32'(rsp_log[r0]), 32'hFE);
        check("t2_rsp1", 32'(rsp_log[r0+1]), 32'hFD);
        check("t2_rsp2", 32'(rsp_log[r0+2]), 32'hFC);
        check("t2_rsp_idx", 32'(rsp_idx_log[r0+2]), 32'h2);
        check("t2_cs_asserts", 32'(n_cs_assert - c0), 32'd1);
        check("t2_cs_low_len", 32'(last_low_len), 32'd59);
        $display("test2 done cs_low_len=%0d", last_low_len);

        // 3: both requesters held continuously, single-byte bursts
        r0 = n_rsp;
        req_data = 16'h2211;
        req_last = 2'b11;
        req      = 2'b11;
        for (int i = 0; i < 4; i++) begin
            k = 0;
            do begin
                @(negedge clk);
                k++;
            end while (req_ack == 2'b00 && k < 300);
            check("t3_ack_wait", 32'(k < 300), 32'd1);
            ack_seq[i] = req_ack;
            $display("burst %0d ack=%b", i, req_ack);
        end
        req = 2'b00;
        repeat (40) @(negedge clk);
        check("t3_ack0", 32'(ack_seq[0]), 32'h1);
        check("t3_ack1", 32'(ack_seq[1]), 32'h2);
        check("t3_ack2", 32'(ack_seq[2]), 32'h1);
        check("t3_ack3", 32'(ack_seq[3]), 32'h2);
        check("t3_rsp0", 32'(rsp_log[r0]), 32'hEE);
        check("t3_rsp1", 32'(rsp_log[r0+1]), 32'hDD);
        check("t3_min_gap", 32'(min_gap), 32'd9);
        check("t3_cs_violations", 32'(n_viol), 32'd0);

        // 4: engine hangs past the watchdog, late spi_end must be ignored
        eng_delay = 100;
        r0 = n_rsp; e0 = n_err; v0 = n_end;
        send_byte(1, 8'h33, 1'b1);
        req[1] = 1'b0;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (err_timeout == 2'b00 && k < 200);
        check("t4_err_latency", 32'(k), 32'd65);
        check("t4_err_owner", 32'(err_timeout), 32'h2);
        repeat (50) @(negedge clk);
        check("t4_no_rsp", 32'(n_rsp - r0), 32'd0);
        check("t4_err_cnt", 32'(n_err - e0), 32'd1);
        check("t4_late_end_seen", 32'(n_end - v0), 32'd1);
        check("t4_cs_low_len", 32'(last_low_len), 32'd73);
        check("t4_cs_released", 32'(cs_n), 32'h3);
        eng_delay = 16;
        send_byte(0, 8'h3C, 1'b1);
        req[0] = 1'b0;
        repeat (40) @(negedge clk);
        check("t4_next_rsp", 32'(rsp_log[r0]), 32'hC3);
        check("t4_next_cnt", 32'(n_rsp - r0), 32'd1);

        // 5: asynchronous reset during WAIT
        send_byte(0, 8'h77, 1'b1);
        req[0] = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        check("t5_async_cs_n", 32'(cs_n), 32'h3);
        check("t5_async_grant", 32'(grant), 32'h0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("t5_send_data", 32'(spi_send_data), 32'h0);
        check("t5_rsp_data", 32'(rsp_data), 32'h0);
        req_last = 2'b11;
        req      = 2'b11;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (req_ack == 2'b00 && k < 300);
        check("t5_rr_ptr_reset", 32'(req_ack), 32'h1);
        req = 2'b00;
        repeat (40) @(negedge clk);
        check("t5_cs_violations", 32'(n_viol), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
